// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel round-robin/fixed-priority memory arbiter, one transaction in flight
module mem_arbiter_rr #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 32,
    parameter int BLK_W      = 128,
    parameter int SIZE_W     = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_CH-1:0]          ch_req_valid_i,
    output logic [NUM_CH-1:0]          ch_req_ready_o,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr_i,
    input  logic [NUM_CH-1:0]          ch_req_rw_i,
    input  logic [NUM_CH*SIZE_W-1:0]   ch_req_size_i,
    input  logic [NUM_CH*BLK_W-1:0]    ch_req_data_i,
    input  logic [NUM_CH-1:0]          ch_req_uncached_i,
    output logic [NUM_CH-1:0]          ch_rsp_valid_o,
    output logic [BLK_W-1:0]           ch_rsp_data_o,
    output logic                       mem_req_valid_o,
    input  logic                       mem_req_ready_i,
    output logic [ADDR_W-1:0]          mem_req_addr_o,
    output logic                       mem_req_rw_o,
    output logic [SIZE_W-1:0]          mem_req_size_o,
    output logic [BLK_W-1:0]           mem_req_data_o,
    output logic                       mem_req_uncached_o,
    input  logic                       mem_rsp_valid_i,
    input  logic [BLK_W-1:0]           mem_rsp_data_i,
    output logic [$clog2(NUM_CH)-1:0]  grant_id_o,
    output logic                       busy_o
);

    localparam int CW = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state;
    logic [NUM_CH-1:0]   pend;
    logic [ADDR_W-1:0]   lat_addr [NUM_CH];
    logic [SIZE_W-1:0]   lat_size [NUM_CH];
    logic [BLK_W-1:0]    lat_data [NUM_CH];
    logic [NUM_CH-1:0]   lat_rw;
    logic [NUM_CH-1:0]   lat_unc;
    logic [CW-1:0]       grant_id;
    logic [CW-1:0]       last_grant;
    logic [CW-1:0]       win_id;
    logic                win_found;
    logic                rsp_fire;

    assign rsp_fire = (state == WAIT) && mem_rsp_valid_i;

    // Search order starts just after the previous winner; fixed priority scans from index 0.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (FIXED_PRIO != 0) begin
                idx = i;
            end else begin
                idx = (int'(last_grant) + 1 + i) % NUM_CH;
            end
            if (!win_found && pend[CW'(idx)]) begin
                win_found = 1'b1;
                win_id    = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state              <= IDLE;
            pend               <= '0;
            last_grant         <= CW'(NUM_CH - 1);
            grant_id           <= '0;
            lat_rw             <= '0;
            lat_unc            <= '0;
            busy_o             <= 1'b0;
            mem_req_valid_o    <= 1'b0;
            mem_req_addr_o     <= '0;
            mem_req_rw_o       <= 1'b0;
            mem_req_size_o     <= '0;
            mem_req_data_o     <= '0;
            mem_req_uncached_o <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                lat_addr[k] <= '0;
                lat_size[k] <= '0;
                lat_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_req_valid_i[k] && !pend[k]) begin
                    pend[k]     <= 1'b1;
                    lat_addr[k] <= ch_req_addr_i[k*ADDR_W +: ADDR_W];
                    lat_size[k] <= ch_req_size_i[k*SIZE_W +: SIZE_W];
                    lat_data[k] <= ch_req_data_i[k*BLK_W +: BLK_W];
                    lat_rw[k]   <= ch_req_rw_i[k];
                    lat_unc[k]  <= ch_req_uncached_i[k];
                end
            end

            case (state)
                IDLE: begin
                    if (win_found) begin
                        state              <= ISSUE;
                        grant_id           <= win_id;
                        last_grant         <= win_id;
                        busy_o             <= 1'b1;
                        mem_req_valid_o    <= 1'b1;
                        mem_req_addr_o     <= lat_addr[win_id];
                        mem_req_rw_o       <= lat_rw[win_id];
                        mem_req_size_o     <= lat_size[win_id];
                        mem_req_data_o     <= lat_data[win_id];
                        mem_req_uncached_o <= lat_unc[win_id];
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        state           <= WAIT;
                        mem_req_valid_o <= 1'b0;
                    end
                end
                WAIT: begin
                    // Latch is released in the delivery cycle; the channel can re-request next cycle.
                    if (mem_rsp_valid_i) begin
                        state              <= IDLE;
                        pend[grant_id]     <= 1'b0;
                        busy_o             <= 1'b0;
                        mem_req_addr_o     <= '0;
                        mem_req_rw_o       <= 1'b0;
                        mem_req_size_o     <= '0;
                        mem_req_data_o     <= '0;
                        mem_req_uncached_o <= 1'b0;
                    end
                end
                default: begin
                    state           <= IDLE;
                    busy_o          <= 1'b0;
                    mem_req_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign ch_req_ready_o = ~pend;
    assign ch_rsp_data_o  = mem_rsp_data_i;
    assign ch_rsp_valid_o = rsp_fire ? ({{(NUM_CH-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign grant_id_o     = grant_id;

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

N-channel memory arbiter between cache-side requesters (icache, dcache, future DMA/PTW ports) and a single memory bus, with one outstanding memory transaction at a time. Each channel has a one-entry request latch. Channels are granted in round-robin or fixed-priority order. The granted request is presented on the memory bus with a valid/ready handshake, and the memory response is routed back to its owner only. The block replaces the fixed two-channel arbiter in the MMU path and adds explicit backpressure in both directions.

## Interface
Parameters:
- NUM_CH, 2 — number of requester channels (≥2); channel 0 is icache by convention.
- ADDR_W, 32 — address width.
- BLK_W, 128 — cache-line width; used for both write data and response data.
- SIZE_W, 2 — rw_size field width; `'0` means full line (NO_SIZE).
- FIXED_PRIO, 0 — 0: round-robin; 1: fixed priority, lowest index wins.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- ch_req_valid_i  in  NUM_CH  request valid, one bit per channel.
- ch_req_ready_o  out  NUM_CH  channel latch empty, so a request can be accepted.
- ch_req_addr_i  in  NUM_CH*ADDR_W  packed addresses; channel k occupies bits [k*ADDR_W +: ADDR_W].
- ch_req_rw_i  in  NUM_CH  1 = write.
- ch_req_size_i  in  NUM_CH*SIZE_W  access size per channel.
- ch_req_data_i  in  NUM_CH*BLK_W  write data per channel.
- ch_req_uncached_i  in  NUM_CH  uncached flag per channel.
- ch_rsp_valid_o  out  NUM_CH  one-cycle response pulse to the owning channel.
- ch_rsp_data_o  out  BLK_W  response data, broadcast to all channels; qualified by ch_rsp_valid_o.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  ADDR_W  granted address.
- mem_req_rw_o  out  1  granted rw.
- mem_req_size_o  out  SIZE_W  granted size.
- mem_req_data_o  out  BLK_W  granted write data.
- mem_req_uncached_o  out  1  granted uncached flag.
- mem_rsp_valid_i  in  1  memory response valid.
- mem_rsp_data_i  in  BLK_W  memory response data.
- grant_id_o  out  $clog2(NUM_CH)  index of the current owner; valid when busy_o = 1.
- busy_o  out  1  a transaction is in ISSUE or WAIT.

## Operation
- **Channel latch:** per-channel pend bit plus stored request fields. ch_req_ready_o[k] = !pend[k].
  - Accept when valid & ready; the latch captures all fields.
  - pend[k] clears at the end of the cycle in which channel k's response is delivered.
- **States:**
  - IDLE: if any pend bit is set, arbitrate, register the winner into grant_id, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_req_valid_o = 1 with the granted latch fields. Go to WAIT on mem_req_ready_i; otherwise hold, with fields stable.
  - WAIT: on mem_rsp_valid_i, ch_rsp_valid_o[grant_id] = 1 in the same cycle, ch_rsp_data_o = mem_rsp_data_i, clear pend[grant_id], go to IDLE.
- **Round-robin:** last_grant register. Search starts at last_grant+1 and wraps modulo NUM_CH. last_grant updates on grant.
- **FIXED_PRIO=1:** the lowest pending index wins; last_grant is ignored.
- **mem_req_\* outputs:** zero outside ISSUE/WAIT. mem_req_valid_o is high only in ISSUE.
- mem_rsp_valid_i outside WAIT is ignored, with no pulse and no state change.
- ch_rsp_data_o = mem_rsp_data_i combinationally, at all times.
- **Simultaneous accept and response on the same channel:** impossible, because ready is low while pend is set. A new request is accepted no earlier than the cycle after the response.
- **Simultaneous events on different channels:** requests accepted while another channel is in flight are latched, and are arbitrated in the next IDLE cycle.

## Timing
- **Reset (asynchronous assert):** state = IDLE, pend = 0, last_grant = NUM_CH-1 (so channel 0 wins first), grant_id = 0.
  - Output values: mem_req_valid_o = 0, all mem_req_\* = 0, ch_rsp_valid_o = 0, ch_req_ready_o = all 1, busy_o = 0, grant_id_o = 0.
- **Reset mid-transaction:** all pending and in-flight requests are dropped. A later mem_rsp_valid_i is ignored because state is IDLE.
- **Latency, with an immediately ready memory:**
  - Accept at cycle 0.
  - Cycle 1: IDLE grant.
  - Cycle 2: ISSUE with mem_req_valid_o = 1.
  - Cycle 3 at the earliest: WAIT response, and ch_rsp_valid_o in that same cycle.
  - Cycle 4: ch_req_ready_o high again.
- **Back-to-back:** one IDLE cycle occurs between consecutive transactions. Minimum issue-to-issue spacing is 3 cycles plus memory latency.
- **Fairness:** with all channels continuously pending, round-robin serves each channel exactly once per NUM_CH grants.

## Test plan
- **Reset values:** assert rst_ni = 0 asynchronously mid-WAIT -> outputs return to the reset values immediately; a response pulse afterwards produces no ch_rsp_valid_o.
- **Single read:** ch1 read, addr 0x8000_0040, memory ready immediately, response 2 cycles after the issue handshake -> mem_req_valid_o in cycle 2, ch_rsp_valid_o[1] for exactly one cycle carrying the data, ch_req_ready_o[1] high the following cycle.
- **Round-robin, NUM_CH=4:** all channels request every cycle -> grant order 0,1,2,3,0,1,…; no channel is granted twice within 4 grants.
- **FIXED_PRIO=1:** ch0 and ch2 re-request continuously -> ch0 always wins; ch2 is granted only when ch0 is not pending.
- **Backpressure:** hold mem_req_ready_i low for 5 cycles during ISSUE -> mem_req_valid_o and all fields stay stable; no state change until ready.
- **Stray response:** mem_rsp_valid_i pulsed while in IDLE or ISSUE -> no ch_rsp_valid_o and no pend change; a write from ch0 (rw=1, size=2, data 0xDEAD…) is forwarded unmodified.
